serial_word_deser: RTL
======================

# serial_word_deser

Serial-to-parallel receiver for the 5-bit universal shift register's serial stream. It collects bits from a `si`/`si_valid` strobe into words, MSB-first or LSB-first. Completed words go into a 2-entry output buffer with a valid/ready handshake. It sits downstream of the shift register's serial output, or of any serial link using the same bit order.

## Interface
- `WIDTH`, 5, word length in bits (≥2)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `si`  in  1  serial data bit
- `si_valid`  in  1  `si` carries a bit this cycle
- `sof`  in  1  start-of-word marker, qualified by `si_valid`
- `msb_first`  in  1  1: first bit lands in `po[WIDTH-1]`; 0: first bit lands in `po[0]`
- `po`  out  WIDTH  head word of output buffer
- `po_valid`  out  1  buffer non-empty
- `po_ready`  in  1  consumer accepts `po` this cycle
- `overflow`  out  1  sticky: a completed word was dropped
- `ovf_clr`  in  1  clears `overflow`
- `frame_err`  out  1  one-cycle pulse: partial word discarded by `sof`
- `bit_cnt`  out  3  bits collected in current word (0..WIDTH-1)

## Operation
- Reset (`rst`=0, async) forces all outputs to 0: `po`, `po_valid`, `overflow`, `frame_err`, `bit_cnt`. It also empties the buffer and the accumulator. A partial word is lost.
- The FSM has two states, IDLE (`bit_cnt`=0) and ACTIVE (1 ≤ `bit_cnt` ≤ WIDTH-1).
- **Direction:** `msb_first` is latched with the first bit of each word (the IDLE accept). Changes to it mid-word have no effect until the next word.
- **Shift on accepted bit** (`si_valid`=1):
  - MSB-first: `acc <= {acc[WIDTH-2:0], si}`.
  - LSB-first: `acc <= {si, acc[WIDTH-1:1]}`.
- **IDLE:** an accepted bit loads the accumulator, sets `bit_cnt`=1 and moves to ACTIVE. `sof` is ignored in IDLE.
- **ACTIVE:** an accepted bit increments `bit_cnt`.
  - On the WIDTH-th bit, the completed word (including that bit) is pushed, `bit_cnt` returns to 0, and the FSM returns to IDLE.
- **ACTIVE with `sof`=1 and `si_valid`=1:**
  - The partial word is discarded and `frame_err` pulses for one cycle.
  - The current bit becomes bit 1 of a new word; `bit_cnt`=1, and `msb_first` is re-latched.
- `sof` without `si_valid` is ignored.
- **Buffer:** 2-entry FIFO. `po` is the oldest entry. A pop occurs when `po_valid`=1 and `po_ready`=1.
- **Push when full:**
  - With no pop in the same cycle, the word is dropped and `overflow` is set.
  - With a pop in the same cycle, the push is accepted and no overflow occurs.
- Push and pop in the same cycle with 1 entry: occupancy stays 1 and `po` shows the new word.
- `overflow` stays set until `ovf_clr`=1. If a set and `ovf_clr` coincide, set wins.
- `po` holds its last value while `po_valid`=0; consumers must not rely on it.

## Timing
- All state updates happen on the rising edge of `clk`, except reset.
- Latency: the word is visible on `po` with `po_valid`=1 on the cycle after the edge that sampled its last bit.
- Minimum one idle-free word takes WIDTH consecutive `si_valid` cycles. Back-to-back words need no gap.
- Throughput is one word per WIDTH cycles. With `po_ready` held at 1, the buffer never fills.
- `po_valid` falls on the edge after the final pop, unless a push occurs on that same edge.
- `frame_err` is high for exactly the cycle after the offending `sof` edge.
- Reset deassertion is expected synchronous to `clk`. The first accepted bit is on the first edge with `rst`=1.

## Test plan
- **MSB-first:** `msb_first`=1, bits 1,0,1,1,0 on 5 consecutive cycles with `po_ready`=1 → `po`=5'b10110 and `po_valid`=1 for one cycle, one cycle after the 5th bit.
- **LSB-first:** `msb_first`=0, same bit sequence 1,0,1,1,0 → `po`=5'b01101.
- **Overflow:** `po_ready`=0, three words 5'h11, 5'h0A, 5'h1F sent → `po`=5'h11, 2 entries held, `overflow`=1.
  - Pop twice → 5'h11 then 5'h0A, and 5'h1F is never seen.
  - `ovf_clr`=1 → `overflow`=0.
- **Full with simultaneous pop:** buffer full with 5'h03, 5'h04; the 5th bit of 5'h05 arrives on the same edge as a pop → no overflow, subsequent pops give 5'h04 then 5'h05.
- **Frame abort:** 3 bits 1,1,1, then `sof`=1 with bit 0, then bits 0,1,0,1 (MSB-first) → `frame_err` pulses once, `bit_cnt`=1 after the `sof` edge, and `po`=5'b00101.
- **Reset mid-word:** 2 bits sent, `rst`=0 asserted between edges → outputs 0 immediately.
  - After release, a full word 1,1,0,0,1 → `po`=5'b11001, with no stale bits.

Source files
------------

// File: rtl/serial_word_deser.sv
// serial_word_deser
//   Serial-to-parallel receiver. It gathers bits strobed by si_valid into
//   WIDTH-bit words, either MSB-first or LSB-first. The bit order is latched
//   with the first bit of each word. Completed words enter a 2-entry FIFO
//   that is drained through a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   si         serial data bit
//   si_valid   si carries a bit this cycle
//   sof        start-of-word marker, qualified by si_valid
//   msb_first  1: first bit ends in po[WIDTH-1]; 0: first bit ends in po[0]
//   po         head word of the output buffer
//   po_valid   buffer non-empty
//   po_ready   consumer accepts po this cycle
//   overflow   sticky: a completed word was dropped
//   ovf_clr    clears overflow (a simultaneous set wins)
//   frame_err  one-cycle pulse: partial word discarded by sof
//   bit_cnt    bits collected in the current word
module serial_word_deser #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    input  logic             sof,
    input  logic             msb_first,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             frame_err,
    output logic [2:0]       bit_cnt
);

    localparam logic [2:0] LAST = 3'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic             dir_q;
    logic [2:0]       cnt;

    logic             start;     // accepted bit opens a new word
    logic             abort;     // sof discards a partial word
    logic             step;      // accepted bit continues the current word
    logic             complete;  // accepted bit is the last bit of the word
    logic             dir;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;

    logic [WIDTH-1:0] mem0, mem1;
    logic [1:0]       occ;
    logic             push, pop;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (si_valid) state_nxt = ACTIVE;
            ACTIVE:  if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and datapath decode
    always_comb begin
        start    = si_valid && ((state == IDLE) || sof);
        abort    = si_valid && sof && (state == ACTIVE);
        step     = si_valid && !sof && (state == ACTIVE);
        complete = step && (cnt == LAST);
        // A new word shifts into a cleared accumulator using the live
        // direction input, so no stale bits survive an abort.
        dir      = start ? msb_first : dir_q;
        base     = start ? '0 : acc;
        shifted  = dir ? {base[WIDTH-2:0], si} : {si, base[WIDTH-1:1]};
    end

    // Accumulator, bit counter, latched direction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (start) begin
            acc   <= shifted;
            cnt   <= 3'd1;
            dir_q <= msb_first;
        end else if (step) begin
            acc   <= shifted;
            cnt   <= complete ? 3'd0 : cnt + 3'd1;
        end
    end

    assign bit_cnt  = cnt;

    // Output FIFO: mem0 is always the head entry.
    assign push     = complete;
    assign po_valid = (occ != 2'd0);
    assign pop      = po_valid && po_ready;
    assign po       = mem0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem0 <= '0;
            mem1 <= '0;
            occ  <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        mem0 <= shifted;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        mem0 <= shifted;
                    end else if (push) begin
                        mem1 <= shifted;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ  <= 2'd0;
                    end
                end
                default: begin
                    if (push && pop) begin
                        mem0 <= mem1;
                        mem1 <= shifted;
                    end else if (pop) begin
                        mem0 <= mem1;
                        occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (push && (occ == 2'd2) && !pop) overflow <= 1'b1;
            else if (ovf_clr)                  overflow <= 1'b0;
        end
    end

endmodule
